// File: rtl/alu_op_initiator.sv
// alu_op_initiator: buffers tagged ALU requests and drives them onto an
// alu_tile one operation per cycle. Tile results come back in order, together
// with their tag and an error flag. Credits make sure the response buffer
// always has room for every operation that has been issued.
module alu_op_initiator #(
  parameter int DATA_W    = 64,
  parameter int MODE_W    = 4,
  parameter int TAG_W     = 4,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TILE_LAT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [MODE_W-1:0] req_mode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              tile_vld,
  output logic [MODE_W-1:0] tile_mode,
  output logic [DATA_W-1:0] tile_a,
  output logic [DATA_W-1:0] tile_b,
  input  logic [DATA_W-1:0] tile_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int RA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam int CW = SA + 2;

  // Request FIFO storage and pointers (one extra wrap bit on each pointer)
  logic [MODE_W-1:0] req_mode_mem [REQ_DEPTH];
  logic [DATA_W-1:0] req_a_mem    [REQ_DEPTH];
  logic [DATA_W-1:0] req_b_mem    [REQ_DEPTH];
  logic [TAG_W-1:0]  req_tag_mem  [REQ_DEPTH];
  logic [RA:0]       req_wr_ptr;
  logic [RA:0]       req_rd_ptr;
  logic              req_empty;
  logic              req_full;
  logic              req_push;

  // Response FIFO storage and pointers
  logic [DATA_W-1:0] rsp_result_mem [RSP_DEPTH];
  logic [TAG_W-1:0]  rsp_tag_mem    [RSP_DEPTH];
  logic              rsp_err_mem    [RSP_DEPTH];
  logic [SA:0]       rsp_wr_ptr;
  logic [SA:0]       rsp_rd_ptr;
  logic [SA:0]       rsp_count;
  logic              rsp_pop;

  // Issue path
  logic [SA:0]       inflight;
  logic [CW-1:0]     credits_used;
  logic              issue;
  logic [MODE_W-1:0] head_mode;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [TAG_W-1:0]  head_tag;
  logic              head_err;
  logic [TAG_W-1:0]  tile_tag;
  logic              tile_err;

  // Capture point, TILE_LAT cycles after the tile_vld cycle
  logic              cap_vld;
  logic [TAG_W-1:0]  cap_tag;
  logic              cap_err;

  assign req_empty = (req_wr_ptr == req_rd_ptr);
  assign req_full  = (req_wr_ptr[RA] != req_rd_ptr[RA]) &&
                     (req_wr_ptr[RA-1:0] == req_rd_ptr[RA-1:0]);
  assign req_ready = !req_full;
  assign req_push  = req_valid && req_ready;

  assign head_mode = req_mode_mem[req_rd_ptr[RA-1:0]];
  assign head_a    = req_a_mem[req_rd_ptr[RA-1:0]];
  assign head_b    = req_b_mem[req_rd_ptr[RA-1:0]];
  assign head_tag  = req_tag_mem[req_rd_ptr[RA-1:0]];
  assign head_err  = (head_mode > MODE_W'(8)) ||
                     (((head_mode == MODE_W'(3)) || (head_mode == MODE_W'(4))) &&
                      (head_b == '0));

  assign rsp_count    = rsp_wr_ptr - rsp_rd_ptr;
  assign credits_used = {1'b0, inflight} + {1'b0, rsp_count};
  assign issue        = !req_empty && (credits_used < CW'(RSP_DEPTH));

  assign rsp_valid  = (rsp_wr_ptr != rsp_rd_ptr);
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign rsp_result = rsp_valid ? rsp_result_mem[rsp_rd_ptr[SA-1:0]] : '0;
  assign rsp_tag    = rsp_valid ? rsp_tag_mem[rsp_rd_ptr[SA-1:0]] : '0;
  assign rsp_err    = rsp_valid ? rsp_err_mem[rsp_rd_ptr[SA-1:0]] : 1'b0;

  assign busy = !req_empty || (inflight != '0) || rsp_valid;

  // Write accepted requests into the request FIFO storage
  always_ff @(posedge clk) begin
    if (req_push) begin
      req_mode_mem[req_wr_ptr[RA-1:0]] <= req_mode;
      req_a_mem[req_wr_ptr[RA-1:0]]    <= req_a;
      req_b_mem[req_wr_ptr[RA-1:0]]    <= req_b;
      req_tag_mem[req_wr_ptr[RA-1:0]]  <= req_tag;
    end
  end

  // Request FIFO pointers: advance on accept and on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
    end else begin
      if (req_push) req_wr_ptr <= req_wr_ptr + 1'b1;
      if (issue)    req_rd_ptr <= req_rd_ptr + 1'b1;
    end
  end

  // Tile operand registers: load on issue, otherwise hold with tile_vld low
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_vld  <= 1'b0;
      tile_mode <= '0;
      tile_a    <= '0;
      tile_b    <= '0;
      tile_tag  <= '0;
      tile_err  <= 1'b0;
    end else if (issue) begin
      tile_vld  <= 1'b1;
      tile_mode <= head_mode;
      tile_a    <= head_a;
      tile_b    <= head_b;
      tile_tag  <= head_tag;
      tile_err  <= head_err;
    end else begin
      tile_vld  <= 1'b0;
    end
  end

  generate
    if (TILE_LAT == 0) begin : g_comb_tile
      assign cap_vld = tile_vld;
      assign cap_tag = tile_tag;
      assign cap_err = tile_err;
    end else begin : g_pipe_tile
      logic [TILE_LAT-1:0] pipe_vld;
      logic [TAG_W-1:0]    pipe_tag [TILE_LAT];
      logic                pipe_err [TILE_LAT];

      // Valid shift chain tracking operations inside the tile; cleared by reset
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_vld <= '0;
        end else begin
          pipe_vld[0] <= tile_vld;
          for (int i = 1; i < TILE_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
      end

      // Tag and error flag travel alongside the valid bit
      always_ff @(posedge clk) begin
        pipe_tag[0] <= tile_tag;
        pipe_err[0] <= tile_err;
        for (int i = 1; i < TILE_LAT; i++) begin
          pipe_tag[i] <= pipe_tag[i-1];
          pipe_err[i] <= pipe_err[i-1];
        end
      end

      assign cap_vld = pipe_vld[TILE_LAT-1];
      assign cap_tag = pipe_tag[TILE_LAT-1];
      assign cap_err = pipe_err[TILE_LAT-1];
    end
  endgenerate

  // In-flight count: up on issue, down on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, cap_vld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Capture tile results into the response FIFO storage
  always_ff @(posedge clk) begin
    if (cap_vld) begin
      rsp_result_mem[rsp_wr_ptr[SA-1:0]] <= tile_result;
      rsp_tag_mem[rsp_wr_ptr[SA-1:0]]    <= cap_tag;
      rsp_err_mem[rsp_wr_ptr[SA-1:0]]    <= cap_err;
    end
  end

  // Response FIFO pointers: advance on capture and on consumer pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
    end else begin
      if (cap_vld) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
    end
  end

endmodule
